// File: rtl/fxp_to_fp16.sv
// rtl/fxp_to_fp16.sv - sign-magnitude 16.16 fixed-point to binary16 converter
// Normalises one bit per clock; valid/ready handshake on both sides.
module fxp_to_fp16 #(
  parameter int ROUND = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [15:0] in_int,
  input  logic [15:0] in_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_fp,
  output logic        out_zero,
  output logic        out_ovf
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] v_q, v_d;
  logic [4:0]  s_q, s_d;
  logic        sign_q, sign_d;
  logic [15:0] fp_q, fp_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  logic [9:0]  man_raw;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_inc;
  logic [10:0] man_sum;
  logic [4:0]  exp_base;
  logic [4:0]  exp_fin;
  logic [9:0]  man_fin;

  // Rounding datapath, only meaningful once v_q[31] is the hidden bit.
  always_comb begin
    man_raw    = v_q[30:21];
    guard_bit  = v_q[20];
    sticky_bit = |v_q[19:0];
    round_inc  = (ROUND != 0) && guard_bit && (sticky_bit || man_raw[0]);
    man_sum    = {1'b0, man_raw} + {10'b0, round_inc};
    exp_base   = 5'd30 - s_q;
    exp_fin    = exp_base + {4'b0, man_sum[10]};
    man_fin    = man_sum[10] ? 10'b0 : man_sum[9:0];
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    s_d     = s_q;
    sign_d  = sign_q;
    fp_d    = fp_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ({in_int, in_frac} == 32'b0) begin
            state_d = DONE;
            fp_d    = {in_sign, 15'b0};
            zero_d  = 1'b1;
            ovf_d   = 1'b0;
          end else if (in_int == 16'b0 && in_frac[15:2] == 14'b0) begin
            // Values 1..3 * 2^-16 land exactly on binary16 subnormals.
            state_d = DONE;
            fp_d    = {in_sign, 5'b0, in_frac[1:0], 8'b0};
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d = NORM;
            v_d     = {in_int, in_frac};
            sign_d  = in_sign;
            s_d     = 5'd0;
          end
        end
      end
      NORM: begin
        if (!v_q[31]) begin
          v_d = v_q << 1;
          s_d = s_q + 5'd1;
        end else begin
          state_d = DONE;
          zero_d  = 1'b0;
          if (exp_fin == 5'h1F) begin
            fp_d  = {sign_q, 5'h1F, 10'b0};
            ovf_d = 1'b1;
          end else begin
            fp_d  = {sign_q, exp_fin, man_fin};
            ovf_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= 32'b0;
      s_q     <= 5'd0;
      sign_q  <= 1'b0;
      fp_q    <= 16'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      fp_q    <= fp_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_fp    = fp_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/fxp_to_fp16.md
Name: fxp_to_fp16

Overview:
- Sequential converter from sign-magnitude fixed-point (16-bit integer + 16-bit fraction) to IEEE-754 binary16.
- Sits directly upstream of the fpm half-precision multiplier and drives its a/b operands.
- Normalises with an iterative left-shift, one bit per clock, so area stays minimal.
- Uses a valid/ready handshake on input and output; conversion time depends on the data.

Parameters:
ROUND, 0, 0 = truncate (mantissa bits below LSB dropped); 1 = round-to-nearest-even

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  converter can accept an operand
in_sign  input  1  sign of operand
in_int  input  16  unsigned integer part
in_frac  input  16  fraction part, bit15 = 2^-1
out_valid  output  1  result valid, held until taken
out_ready  input  1  downstream accepts result
out_fp  output  16  binary16 result {sign, exp[4:0], man[9:0]}
out_zero  output  1  result is signed zero (qualified by out_valid)
out_ovf  output  1  rounding overflowed to infinity (qualified by out_valid)

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low rst_n.
  - State returns to IDLE; out_valid, out_fp, out_zero and out_ovf are 0.
  - in_ready is 1 once in IDLE.
- Reset mid-conversion: operation aborts and no result is produced.
- Working register v[31:0] = {in_int, in_frac}. Value represented = v * 2^-16.
- FSM states: IDLE, NORM, DONE.
- in_ready = (state == IDLE), combinational from state. Accept occurs when in_valid && in_ready.
- Accept in IDLE, branching on the operand:
  - v == 0: go to DONE; out_fp = {in_sign, 15'b0}; out_zero = 1.
  - in_int == 0 and in_frac[15:2] == 0 (subnormal, v = 1..3): go to DONE; out_fp = {in_sign, 5'b0, in_frac[1:0], 8'b0}. This is exact.
  - Otherwise: load v and sign, clear shift count s, go to NORM.
- NORM:
  - If v[31] == 0: v <= v << 1; s <= s + 1.
  - If v[31] == 1: compute the result and go to DONE.
    - exp = 30 - s. Range is 1..30, so no overflow is possible before rounding.
    - man = v[30:21]; G = v[20]; S = |v[19:0].
- Rounding:
  - ROUND=0: man is used unchanged.
  - ROUND=1: increment man when G && (S || man[0]).
  - Mantissa carry-out: man = 0 and exp = exp + 1.
  - If exp reaches 31: out_fp = {sign, 5'h1F, 10'b0} and out_ovf = 1.
- Latency:
  - Zero and subnormal operands: out_valid is high after the 1st edge following accept.
  - Normal operands: out_valid is high after edge s+2 following accept, where s = leading-zero count of v (0..29).
- DONE:
  - out_valid = 1; out_fp, out_zero and out_ovf stay stable until out_valid && out_ready.
  - On that edge: return to IDLE and clear out_valid.
  - No same-cycle accept of a new operand; in_ready is 0 throughout DONE.
- in_valid is ignored outside IDLE. Input data needs to be stable only on the accept edge.
- Throughput: one conversion in flight at a time.

Test Plan:
- 2.5 (in_int=2, in_frac=0x8000, sign 0) -> out_fp = 0x4100 after 16 edges (s=14); out_zero=0, out_ovf=0.
- 1.5 (in_int=1, in_frac=0x8000, sign 0) -> 0x3E00. Then the same value with sign 1 -> 0xBE00.
- Zero with sign 1 -> 0x8000 and out_zero=1 one edge after accept. Also in_int=0, in_frac=0x0001 -> 0x0100 (subnormal) one edge after accept.
- in_int=0xFFFF, in_frac=0xFFFF: ROUND=0 -> 0x7BFF, out_ovf=0; ROUND=1 -> 0x7C00, out_ovf=1.
- ROUND=1 ties: in_int=2049 -> 0x6800 (tie, rounds to even, down); in_int=2051 -> 0x6802 (tie, rounds up).
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles while toggling in_valid with new data. out_fp must stay stable, in_ready must stay 0, and no new accept may occur.
  - Assert rst_n=0 mid-NORM. All outputs must go to 0 asynchronously, with no spurious out_valid after release.
